// File: rtl/coffee_order_panel.sv
// Front-panel order entry: debounced keys, drink/sugar selection, bean check,
// and the bean_check/start_btn/done exchange with the coffee machine controller.
module coffee_order_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DONE_TIMEOUT    = 16,
  parameter int BEAN_MIN        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next,
  input  logic       key_sugar,
  input  logic       key_brew,
  input  logic [3:0] bean_level,
  input  logic       done,
  output logic       bean_check,
  output logic       start_btn,
  output logic [2:0] mode_select,
  output logic       busy,
  output logic       bean_low,
  output logic       error,
  output logic [7:0] drink_count,
  output logic [2:0] dbg_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(DONE_TIMEOUT - 1);
  localparam logic [3:0]    BEAN_MIN_L = 4'(BEAN_MIN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ANNOUNCE = 3'd1,
    S_GAP      = 3'd2,
    S_ARM      = 3'd3,
    S_WAIT     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  // Key bit order everywhere: [0]=next, [1]=sugar, [2]=brew.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q, level_q, press_q;
  logic [DW-1:0] db_cnt_q [3];

  assign raw = {key_brew, key_sugar, key_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      level_q <= 3'b000;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DEB_LAST) begin
            level_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic next_p, sugar_p, brew_p, beans_ok;
  assign next_p   = press_q[0];
  assign sugar_p  = press_q[1];
  assign brew_p   = press_q[2];
  assign beans_ok = (bean_level >= BEAN_MIN_L);

  state_t        state_q;
  logic [1:0]    drink_q, drink_d;
  logic          sugar_q, sugar_d;
  logic [TW-1:0] tmo_cnt_q;
  logic          bean_check_q, start_btn_q, busy_q, bean_low_q, error_q;
  logic [2:0]    mode_select_q;
  logic [7:0]    drink_count_q;

  always_comb begin
    drink_d = drink_q;
    sugar_d = sugar_q;
    if (state_q == S_IDLE) begin
      if (next_p)  drink_d = (drink_q == 2'd2) ? 2'd0 : drink_q + 2'd1;
      if (sugar_p) sugar_d = ~sugar_q;
    end
  end

  // Controller exchange: bean_check pulses one cycle in ANNOUNCE, start_btn one
  // cycle in ARM (two cycles later); the controller answers with a one-cycle
  // done, honoured only in WAIT_DONE, and done beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drink_q       <= 2'd0;
      sugar_q       <= 1'b1;
      tmo_cnt_q     <= '0;
      bean_check_q  <= 1'b0;
      start_btn_q   <= 1'b0;
      mode_select_q <= 3'd0;
      busy_q        <= 1'b0;
      bean_low_q    <= 1'b0;
      error_q       <= 1'b0;
      drink_count_q <= 8'd0;
    end else begin
      bean_check_q  <= 1'b0;
      start_btn_q   <= 1'b0;
      bean_low_q    <= (bean_level < BEAN_MIN_L);
      drink_q       <= drink_d;
      sugar_q       <= sugar_d;
      mode_select_q <= {drink_d, ~sugar_d};
      case (state_q)
        S_IDLE: begin
          if (brew_p && beans_ok) begin
            state_q      <= S_ANNOUNCE;
            bean_check_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_ANNOUNCE: state_q <= S_GAP;
        S_GAP: begin
          state_q     <= S_ARM;
          start_btn_q <= 1'b1;
        end
        S_ARM: begin
          state_q   <= S_WAIT;
          tmo_cnt_q <= '0;
        end
        S_WAIT: begin
          if (done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (drink_count_q != 8'hFF) drink_count_q <= drink_count_q + 8'd1;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        S_ERROR: begin
          if (brew_p) begin
            state_q <= S_IDLE;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bean_check  = bean_check_q;
  assign start_btn   = start_btn_q;
  assign mode_select = mode_select_q;
  assign busy        = busy_q;
  assign bean_low    = bean_low_q;
  assign error       = error_q;
  assign drink_count = drink_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_coffee_order_panel.sv
// Bench for coffee_order_panel: directed order scenarios plus random key/done
// traffic, all checked every cycle against a phase-based model of the panel.
module tb_coffee_order_panel;

  localparam int D = 4;
  localparam int T = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_next = 1'b0, key_sugar = 1'b0, key_brew = 1'b0;
  logic [3:0] bean_level = 4'd5;
  logic       done = 1'b0;
  logic       bean_check, start_btn, busy, bean_low, error;
  logic [2:0] mode_select, dbg_state;
  logic [7:0] drink_count;

  always #5 clk = ~clk;

  coffee_order_panel #(.DEBOUNCE_CYCLES(D), .DONE_TIMEOUT(T), .BEAN_MIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_next(key_next), .key_sugar(key_sugar),
    .key_brew(key_brew), .bean_level(bean_level), .done(done),
    .bean_check(bean_check), .start_btn(start_btn), .mode_select(mode_select),
    .busy(busy), .bean_low(bean_low), .error(error), .drink_count(drink_count),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: -1 idle, 0 = cycle A (bean_check), 2 = A+2 (start_btn), >=3 waiting
  int         m_phase, m_err_state, m_error, m_drink, m_sugar, m_count, m_bean_low;
  int         m_acc[3];
  int         m_press[3];
  logic [2:0] hist[$];

  task automatic model_reset();
    m_phase = -1; m_err_state = 0; m_error = 0;
    m_drink = 0; m_sugar = 1; m_count = 0; m_bean_low = 0;
    for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_press[k] = 0; end
    hist.delete();
    repeat (D + 2) hist.push_back(3'b000);
  endtask

  task automatic model_step();
    logic [2:0] e;
    int         n, newp[3];
    bit         all_diff;
    if (m_err_state != 0) begin
      if (m_press[2] != 0) begin m_err_state = 0; m_error = 0; end
    end else if (m_phase < 0) begin
      if (m_press[0] != 0) m_drink = (m_drink + 1) % 3;
      if (m_press[1] != 0) m_sugar = 1 - m_sugar;
      if (m_press[2] != 0 && bean_level >= 2) m_phase = 0;
    end else if (m_phase < 3) begin
      m_phase++;
    end else if (done) begin
      if (m_count < 255) m_count++;
      m_phase = -1;
    end else if (m_phase - 3 == T - 1) begin
      m_error = 1; m_err_state = 1; m_phase = -1;
    end else begin
      m_phase++;
    end
    m_bean_low = (bean_level < 2) ? 1 : 0;
    // A key level is accepted once the last D synchronized samples (raw two
    // edges back) all disagree with the accepted level.
    hist.push_back({key_brew, key_sugar, key_next});
    n = hist.size();
    for (int k = 0; k < 3; k++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        e = hist[n - 3 - j];
        if (int'(e[k]) == m_acc[k]) all_diff = 1'b0;
      end
      newp[k] = 0;
      if (all_diff) begin
        m_acc[k] = 1 - m_acc[k];
        newp[k]  = m_acc[k];
      end
    end
    for (int k = 0; k < 3; k++) m_press[k] = newp[k];
    while (hist.size() > D + 3) void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("bean_check", bean_check, (m_phase == 0) ? 1 : 0);
        check("start_btn", start_btn, (m_phase == 2) ? 1 : 0);
        check("mode_select", mode_select, 2 * m_drink + ((m_sugar != 0) ? 0 : 1));
        check("busy", busy, (m_phase >= 0 || m_err_state != 0) ? 1 : 0);
        check("bean_low", bean_low, m_bean_low);
        check("error", error, m_error);
        check("drink_count", drink_count, m_count);
        check("dbg_idle", (dbg_state == 3'd0) ? 1 : 0,
              (m_phase < 0 && m_err_state == 0) ? 1 : 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_next  = v;
      1: key_sugar = v;
      default: key_brew = v;
    endcase
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b1);
    repeat (hold) @(negedge clk);
    set_key(k, 1'b0);
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bean_check"}, bean_check, 0);
    check({tag, "_start_btn"}, start_btn, 0);
    check({tag, "_mode"}, mode_select, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bean_low"}, bean_low, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_count"}, drink_count, 0);
  endtask

  // Order observation results, relative to the brew key going high (cycle 0).
  int o_a, o_s, o_e, o_busy_any, o_busy_a6, o_nb, o_ns, o_both;

  task automatic run_order(input int done_at, input int rst_at);
    o_a = -1; o_s = -1; o_e = -1; o_busy_any = 0; o_busy_a6 = -1;
    o_nb = 0; o_ns = 0; o_both = 0;
    key_brew = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) key_brew = 1'b0;
      done = 1'b0;
      if (bean_check && o_a < 0) o_a = k;
      if (start_btn && o_s < 0) o_s = k;
      if (error && o_e < 0) o_e = k;
      if (bean_check) o_nb++;
      if (start_btn) o_ns++;
      if (bean_check && start_btn) o_both++;
      if (busy) o_busy_any = 1;
      if (o_a >= 0 && k == o_a + 6) o_busy_a6 = busy;
      if (o_a >= 0 && k == o_a + done_at) done = 1'b1;
      if (o_a >= 0 && k == o_a + rst_at) begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
      end
      if (o_a >= 0 && k == o_a + rst_at + 2) #1 rst_n = 1'b1;
    end
    done = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  int hold[3];

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // selection: 0 -> 2 -> 4 -> 5, then wrap to 1
    press(0, 8); check("sel_next1", mode_select, 2);
    press(0, 8); check("sel_next2", mode_select, 4);
    press(1, 8); check("sel_sugar", mode_select, 5);
    press(0, 8); check("sel_wrap", mode_select, 1);
    press(0, 8); check("sel_mode3", mode_select, 3);

    // nominal order
    bean_level = 4'd5;
    run_order(5, 1000);
    check("nom_bean_check_cycle", o_a, 2 + D + 1);
    check("nom_start_cycle", o_s, o_a + 2);
    check("nom_one_bean_check", o_nb, 1);
    check("nom_one_start", o_ns, 1);
    check("nom_no_overlap", o_both, 0);
    check("nom_busy_a6", o_busy_a6, 0);
    check("nom_count", drink_count, 1);
    check("nom_mode_kept", mode_select, 3);

    // low beans
    bean_level = 4'd1;
    run_order(5, 1000);
    check("low_no_bean_check", o_nb, 0);
    check("low_no_start", o_ns, 0);
    check("low_never_busy", o_busy_any, 0);
    check("low_flag", bean_low, 1);
    bean_level = 4'd5;
    repeat (2) @(negedge clk);

    // debounce
    press(0, 3);  check("deb_glitch", mode_select, 3);
    press(0, 10); check("deb_long", mode_select, 5);

    // timeout, ignored next press, brew recovery
    run_order(1000, 1000);
    check("tmo_error_cycle", o_e, o_a + 3 + T);
    press(0, 8);
    check("tmo_next_ignored", mode_select, 5);
    check("tmo_error_held", error, 1);
    run_order(1000, 1000);
    check("rec_error_clear", error, 0);
    check("rec_no_bean_check", o_nb, 0);
    check("rec_no_start", o_ns, 0);
    check("rec_busy", busy, 0);

    // done on the last WAIT_DONE cycle
    run_order(2 + T, 1000);
    check("edge_no_error", o_e, -1);
    check("edge_count", drink_count, 2);

    // random key / done / bean traffic
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (hold[k] > 0) hold[k]--;
        else if ($urandom_range(0, 9) == 0) begin
          set_key(k, $urandom_range(0, 1) == 1);
          hold[k] = $urandom_range(1, 10);
        end
      end
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) bean_level = 4'($urandom_range(0, 15));
    end
    key_next = 1'b0; key_sugar = 1'b0; key_brew = 1'b0; done = 1'b0;
    bean_level = 4'd5;
    repeat (40) @(negedge clk);
    if (error) press(2, 8);

    // saturation
    for (int n = 0; n < 260; n++) run_order($urandom_range(3, 2 + T), 1000);
    check("sat_count", drink_count, 255);

    // reset in WAIT_DONE
    run_order(1000, 4);
    check("rst_after_count", drink_count, 0);
    check("rst_after_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
